// File: rtl/mips_branch_pkg.sv
// Shared constants for the ID-stage branch/jump sequencer: MIPS opcode,
// REGIMM rt and SPECIAL funct encodings, the sequencer FSM state enum,
// the implicit link register, and a branch-offset helper.
package mips_branch_pkg;

  // Primary opcodes of the control-transfer instructions
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;

  // REGIMM subcodes carried in the rt field
  localparam logic [4:0] RT_BLTZ    = 5'b00000;
  localparam logic [4:0] RT_BGEZ    = 5'b00001;
  localparam logic [4:0] RT_BLTZAL  = 5'b10000;
  localparam logic [4:0] RT_BGEZAL  = 5'b10001;

  // SPECIAL funct codes
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  // Implicit link register for JAL / BLTZAL / BGEZAL
  localparam logic [4:0] LINK_REG   = 5'd31;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    REDIRECT = 2'd2
  } seq_state_t;

  // Sign-extended word offset of a conditional branch: imm16 << 2
  function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Decodes the instruction in ID and evaluates its branch condition/target.
// Latency: purely combinational. Backpressure: none (no state, no handshake).
// Ports:
//   opcode/rt/funct/id_imm26 - instruction fields of the ID instruction
//   rs_value/rt_value        - forwarded operands used by the compare
//   id_pc                    - PC of the instruction in ID
//   is_cti     - instruction is a supported branch/jump
//   needs_ops  - outcome depends on rs/rt (everything except J/JAL)
//   taken      - control transfer is taken
//   links      - instruction writes a link register
//   link_is_rd - link register comes from rd (JALR) instead of $31
//   next_pc    - taken target; the caller falls back to fetch pc+4
module branch_cond_eval
  import mips_branch_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [4:0]  rt,
  input  logic [5:0]  funct,
  input  logic [31:0] rs_value,
  input  logic [31:0] rt_value,
  input  logic [31:0] id_pc,
  input  logic [25:0] id_imm26,
  output logic        is_cti,
  output logic        needs_ops,
  output logic        taken,
  output logic        links,
  output logic        link_is_rd,
  output logic [31:0] next_pc
);

  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_target;
  logic [31:0] w_j_target;
  logic        w_rs_neg;
  logic        w_rs_zero;

  assign w_pc_plus4  = id_pc + 32'd4;
  assign w_br_target = w_pc_plus4 + branch_offset(id_imm26[15:0]);
  // Jump region is taken from the delay-slot address, not id_pc itself
  assign w_j_target  = {w_pc_plus4[31:28], id_imm26, 2'b00};

  // Signed compares against zero reduce to sign bit and zero test
  assign w_rs_neg  = rs_value[31];
  assign w_rs_zero = (rs_value == 32'd0);

  always_comb begin
    is_cti     = 1'b0;
    needs_ops  = 1'b1;
    taken      = 1'b0;
    links      = 1'b0;
    link_is_rd = 1'b0;
    next_pc    = w_br_target;
    case (opcode)
      OP_BEQ: begin
        is_cti = 1'b1;
        taken  = (rs_value == rt_value);
      end
      OP_BNE: begin
        is_cti = 1'b1;
        taken  = (rs_value != rt_value);
      end
      OP_BLEZ: begin
        is_cti = 1'b1;
        taken  = w_rs_neg | w_rs_zero;
      end
      OP_BGTZ: begin
        is_cti = 1'b1;
        taken  = !w_rs_neg && !w_rs_zero;
      end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ: begin
            is_cti = 1'b1;
            taken  = w_rs_neg;
          end
          RT_BGEZ: begin
            is_cti = 1'b1;
            taken  = !w_rs_neg;
          end
          RT_BLTZAL: begin
            is_cti = 1'b1;
            taken  = w_rs_neg;
            links  = 1'b1;
          end
          RT_BGEZAL: begin
            is_cti = 1'b1;
            taken  = !w_rs_neg;
            links  = 1'b1;
          end
          default: is_cti = 1'b0;
        endcase
      end
      OP_J: begin
        is_cti    = 1'b1;
        needs_ops = 1'b0;
        taken     = 1'b1;
        next_pc   = w_j_target;
      end
      OP_JAL: begin
        is_cti    = 1'b1;
        needs_ops = 1'b0;
        taken     = 1'b1;
        links     = 1'b1;
        next_pc   = w_j_target;
      end
      OP_SPECIAL: begin
        if (funct == FN_JR || funct == FN_JALR) begin
          is_cti     = 1'b1;
          taken      = 1'b1;
          next_pc    = rs_value;
          links      = (funct == FN_JALR);
          link_is_rd = (funct == FN_JALR);
        end
      end
      default: is_cti = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_pc_sequencer.sv
// Owns the fetch PC and sequences it through branches/jumps resolved in ID.
// Latency: redirect visible on pc the cycle after dispatch; dispatch outputs
//   (link_we, branch_taken, ifid_write_en, id_bubble) are combinational.
// Backpressure: if_ready low holds pc; a resolved redirect waits in REDIRECT;
//   operands_ready low on a CTI stalls in STALL with ID->EX bubbles.
// Ports:
//   clk, reset (sync, active-high); if_ready from fetch
//   id_* instruction fields, rs/rt_value + operands_ready from forwarding
//   pc, ifid_write_en, id_bubble, link_we/rd/data, branch_taken,
//   redirect_pending, br_count, br_taken_count
module branch_pc_sequencer
  import mips_branch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   if_ready,
  input  logic                   id_valid,
  input  logic [31:0]            id_pc,
  input  logic [5:0]             id_opcode,
  input  logic [4:0]             id_rt,
  input  logic [4:0]             id_rd,
  input  logic [5:0]             id_funct,
  input  logic [25:0]            id_imm26,
  input  logic [31:0]            rs_value,
  input  logic [31:0]            rt_value,
  input  logic                   operands_ready,
  output logic [31:0]            pc,
  output logic                   ifid_write_en,
  output logic                   id_bubble,
  output logic                   link_we,
  output logic [4:0]             link_rd,
  output logic [31:0]            link_data,
  output logic                   branch_taken,
  output logic                   redirect_pending,
  output logic [COUNT_WIDTH-1:0] br_count,
  output logic [COUNT_WIDTH-1:0] br_taken_count
);

  seq_state_t             r_state;
  logic [31:0]            r_pc;
  logic [31:0]            r_target_q;
  logic [COUNT_WIDTH-1:0] r_br_count;
  logic [COUNT_WIDTH-1:0] r_br_taken_count;

  logic        w_is_cti;
  logic        w_needs_ops;
  logic        w_taken;
  logic        w_links;
  logic        w_link_is_rd;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;
  logic        w_cti;
  logic        w_ops_ok;
  logic        w_dispatch;

  branch_cond_eval u_cond (
    .opcode     (id_opcode),
    .rt         (id_rt),
    .funct      (id_funct),
    .rs_value   (rs_value),
    .rt_value   (rt_value),
    .id_pc      (id_pc),
    .id_imm26   (id_imm26),
    .is_cti     (w_is_cti),
    .needs_ops  (w_needs_ops),
    .taken      (w_taken),
    .links      (w_links),
    .link_is_rd (w_link_is_rd),
    .next_pc    (w_target)
  );

  // Not-taken continues past the delay slot currently being fetched at pc
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_next_pc  = w_taken ? w_target : w_pc_plus4;

  assign w_cti    = id_valid & w_is_cti;
  assign w_ops_ok = !w_needs_ops || operands_ready;

  // The single point at which a CTI is resolved; REDIRECT never dispatches,
  // so links and counters fire exactly once per CTI.
  assign w_dispatch = !reset &&
                      (((r_state == RUN) && w_cti && w_ops_ok) ||
                       ((r_state == STALL) && operands_ready));

  always_comb begin
    ifid_write_en = 1'b0;
    id_bubble     = 1'b1;
    link_we       = 1'b0;
    branch_taken  = 1'b0;
    if (!reset) begin
      if (w_dispatch) begin
        id_bubble     = 1'b0;
        link_we       = w_links;
        branch_taken  = w_taken;
        ifid_write_en = if_ready;
      end else if (r_state == RUN && !w_cti) begin
        ifid_write_en = if_ready;
        id_bubble     = !if_ready;
      end else if (r_state == REDIRECT) begin
        ifid_write_en = if_ready;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= RUN;
      r_pc             <= RESET_PC;
      r_target_q       <= 32'd0;
      r_br_count       <= '0;
      r_br_taken_count <= '0;
    end else begin
      if (w_dispatch) begin
        if (if_ready) begin
          r_pc    <= w_next_pc;
          r_state <= RUN;
        end else begin
          r_target_q <= w_next_pc;
          r_state    <= REDIRECT;
        end
        if (r_br_count != '1) begin
          r_br_count <= r_br_count + 1'b1;
        end
        if (w_taken && r_br_taken_count != '1) begin
          r_br_taken_count <= r_br_taken_count + 1'b1;
        end
      end else begin
        case (r_state)
          RUN: begin
            if (!w_cti) begin
              if (if_ready) begin
                r_pc <= w_pc_plus4;
              end
            end else begin
              // A CTI that did not dispatch is waiting on forwarding
              r_state <= STALL;
            end
          end
          STALL: r_state <= STALL;
          REDIRECT: begin
            if (if_ready) begin
              r_pc    <= r_target_q;
              r_state <= RUN;
            end
          end
          default: r_state <= RUN;
        endcase
      end
    end
  end

  assign pc               = r_pc;
  assign redirect_pending = (r_state == REDIRECT);
  assign link_rd          = w_link_is_rd ? id_rd : LINK_REG;
  assign link_data        = id_pc + 32'd8;
  assign br_count         = r_br_count;
  assign br_taken_count   = r_br_taken_count;

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Directed bench for branch_pc_sequencer: branches, jumps, stall, redirect,
// reset during redirect, and counter saturation on a narrow-counter instance.
module tb_branch_pc_sequencer;
  import mips_branch_pkg::*;

  logic        clk;
  logic        reset;
  logic        if_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [5:0]  id_funct;
  logic [25:0] id_imm26;
  logic [31:0] rs_value;
  logic [31:0] rt_value;
  logic        operands_ready;

  logic [31:0] pc;
  logic        ifid_write_en;
  logic        id_bubble;
  logic        link_we;
  logic [4:0]  link_rd;
  logic [31:0] link_data;
  logic        branch_taken;
  logic        redirect_pending;
  logic [15:0] br_count;
  logic [15:0] br_taken_count;

  logic [31:0] s_pc;
  logic        s_ifid_write_en;
  logic        s_id_bubble;
  logic        s_link_we;
  logic [4:0]  s_link_rd;
  logic [31:0] s_link_data;
  logic        s_branch_taken;
  logic        s_redirect_pending;
  logic [1:0]  s_br_count;
  logic [1:0]  s_br_taken_count;

  int checks = 0;
  int errors = 0;

  branch_pc_sequencer #(.RESET_PC(32'h0000_0000), .COUNT_WIDTH(16)) u_dut (
    .clk(clk), .reset(reset), .if_ready(if_ready), .id_valid(id_valid),
    .id_pc(id_pc), .id_opcode(id_opcode), .id_rt(id_rt), .id_rd(id_rd),
    .id_funct(id_funct), .id_imm26(id_imm26), .rs_value(rs_value),
    .rt_value(rt_value), .operands_ready(operands_ready),
    .pc(pc), .ifid_write_en(ifid_write_en), .id_bubble(id_bubble),
    .link_we(link_we), .link_rd(link_rd), .link_data(link_data),
    .branch_taken(branch_taken), .redirect_pending(redirect_pending),
    .br_count(br_count), .br_taken_count(br_taken_count)
  );

  branch_pc_sequencer #(.RESET_PC(32'h0000_0000), .COUNT_WIDTH(2)) u_sat (
    .clk(clk), .reset(reset), .if_ready(if_ready), .id_valid(id_valid),
    .id_pc(id_pc), .id_opcode(id_opcode), .id_rt(id_rt), .id_rd(id_rd),
    .id_funct(id_funct), .id_imm26(id_imm26), .rs_value(rs_value),
    .rt_value(rt_value), .operands_ready(operands_ready),
    .pc(s_pc), .ifid_write_en(s_ifid_write_en), .id_bubble(s_id_bubble),
    .link_we(s_link_we), .link_rd(s_link_rd), .link_data(s_link_data),
    .branch_taken(s_branch_taken), .redirect_pending(s_redirect_pending),
    .br_count(s_br_count), .br_taken_count(s_br_taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid       = 1'b0;
    id_pc          = 32'd0;
    id_opcode      = OP_SPECIAL;
    id_rt          = 5'd0;
    id_rd          = 5'd0;
    id_funct       = 6'd0;
    id_imm26       = 26'd0;
    rs_value       = 32'd0;
    rt_value       = 32'd0;
    operands_ready = 1'b1;
  endtask

  task automatic cti(input logic [5:0] op, input logic [4:0] rt, input logic [5:0] fn,
                     input logic [31:0] ipc, input logic [25:0] imm,
                     input logic [31:0] rsv, input logic [31:0] rtv);
    id_valid  = 1'b1;
    id_opcode = op;
    id_rt     = rt;
    id_funct  = fn;
    id_pc     = ipc;
    id_imm26  = imm;
    rs_value  = rsv;
    rt_value  = rtv;
  endtask

  initial begin
    reset    = 1'b1;
    if_ready = 1'b1;
    idle();
    #1;
    chk("rst_ifid_we", {31'd0, ifid_write_en}, 32'd0);
    chk("rst_bubble",  {31'd0, id_bubble},     32'd1);
    chk("rst_link_we", {31'd0, link_we},       32'd0);
    chk("rst_taken",   {31'd0, branch_taken},  32'd0);
    tick();
    chk("rst_pc",       pc,                          32'd0);
    chk("rst_br_count", {16'd0, br_count},           32'd0);
    chk("rst_redirect", {31'd0, redirect_pending},   32'd0);
    tick();
    reset = 1'b0;

    // Sequential fetch and fetch backpressure
    #1;
    chk("seq_ifid_we", {31'd0, ifid_write_en}, 32'd1);
    chk("seq_bubble",  {31'd0, id_bubble},     32'd0);
    tick();
    chk("seq_pc", pc, 32'h4);
    if_ready = 1'b0;
    #1;
    chk("hold_bubble",  {31'd0, id_bubble},     32'd1);
    chk("hold_ifid_we", {31'd0, ifid_write_en}, 32'd0);
    tick();
    chk("hold_pc", pc, 32'h4);
    if_ready = 1'b1;

    // BEQ taken: 0x104 + 0x10
    cti(OP_BEQ, 5'd0, 6'd0, 32'h100, 26'h0004, 32'd5, 32'd5);
    #1;
    chk("beq_taken",   {31'd0, branch_taken},  32'd1);
    chk("beq_bubble",  {31'd0, id_bubble},     32'd0);
    chk("beq_ifid_we", {31'd0, ifid_write_en}, 32'd1);
    chk("beq_link_we", {31'd0, link_we},       32'd0);
    tick();
    chk("beq_pc",       pc,                      32'h114);
    chk("beq_br_cnt",   {16'd0, br_count},       32'd1);
    chk("beq_tk_cnt",   {16'd0, br_taken_count}, 32'd1);
    idle();
    #1;
    chk("beq_pulse_end", {31'd0, branch_taken}, 32'd0);

    // BNE not taken: fall through past the delay slot
    cti(OP_BNE, 5'd0, 6'd0, 32'h100, 26'h0004, 32'd5, 32'd5);
    #1;
    chk("bne_taken", {31'd0, branch_taken}, 32'd0);
    tick();
    chk("bne_pc",     pc,                      32'h118);
    chk("bne_br_cnt", {16'd0, br_count},       32'd2);
    chk("bne_tk_cnt", {16'd0, br_taken_count}, 32'd1);

    // BLTZ with negative rs, backward offset: 0x104 - 8
    cti(OP_REGIMM, RT_BLTZ, 6'd0, 32'h100, 26'h0FFFE, 32'hFFFF_FFFF, 32'd0);
    #1;
    chk("bltz_taken", {31'd0, branch_taken}, 32'd1);
    tick();
    chk("bltz_pc", pc, 32'hFC);

    // BGTZ with most-negative rs must not be taken
    cti(OP_BGTZ, 5'd0, 6'd0, 32'h100, 26'h0004, 32'h8000_0000, 32'd0);
    #1;
    chk("bgtz_taken", {31'd0, branch_taken}, 32'd0);
    tick();
    chk("bgtz_pc",     pc,                      32'h100);
    chk("bgtz_br_cnt", {16'd0, br_count},       32'd4);
    chk("bgtz_tk_cnt", {16'd0, br_taken_count}, 32'd2);

    // BAL (BGEZAL rs=$0) waiting three cycles on forwarding
    cti(OP_REGIMM, RT_BGEZAL, 6'd0, 32'h100, 26'h0004, 32'd0, 32'd0);
    operands_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_bubble",  {31'd0, id_bubble},     32'd1);
      chk("stall_ifid_we", {31'd0, ifid_write_en}, 32'd0);
      chk("stall_link_we", {31'd0, link_we},       32'd0);
      tick();
      chk("stall_pc", pc, 32'h100);
    end
    operands_ready = 1'b1;
    #1;
    chk("bal_link_we",   {31'd0, link_we},       32'd1);
    chk("bal_link_rd",   {27'd0, link_rd},       32'd31);
    chk("bal_link_data", link_data,              32'h108);
    chk("bal_taken",     {31'd0, branch_taken},  32'd1);
    chk("bal_ifid_we",   {31'd0, ifid_write_en}, 32'd1);
    tick();
    chk("bal_pc",     pc,                      32'h114);
    chk("bal_br_cnt", {16'd0, br_count},       32'd5);
    idle();
    #1;
    chk("bal_link_once", {31'd0, link_we}, 32'd0);

    // JAL with fetch busy for two cycles
    cti(OP_JAL, 5'd0, 6'd0, 32'h100, 26'h0000400, 32'd0, 32'd0);
    operands_ready = 1'b0;
    if_ready       = 1'b0;
    #1;
    chk("jal_link_we",   {31'd0, link_we},       32'd1);
    chk("jal_taken",     {31'd0, branch_taken},  32'd1);
    chk("jal_ifid_we",   {31'd0, ifid_write_en}, 32'd0);
    chk("jal_link_data", link_data,              32'h108);
    tick();
    chk("jal_redir1", {31'd0, redirect_pending}, 32'd1);
    chk("jal_pc_hold", pc,                       32'h114);
    chk("jal_br_cnt1", {16'd0, br_count},        32'd6);
    #1;
    chk("jal_redir_link_we", {31'd0, link_we},      32'd0);
    chk("jal_redir_bubble",  {31'd0, id_bubble},    32'd1);
    chk("jal_redir_taken",   {31'd0, branch_taken}, 32'd0);
    tick();
    chk("jal_redir2",  {31'd0, redirect_pending}, 32'd1);
    chk("jal_br_cnt2", {16'd0, br_count},         32'd6);
    if_ready = 1'b1;
    #1;
    chk("jal_rel_ifid_we", {31'd0, ifid_write_en}, 32'd1);
    chk("jal_rel_link_we", {31'd0, link_we},       32'd0);
    tick();
    chk("jal_pc",     pc,                       32'h1000);
    chk("jal_redir0", {31'd0, redirect_pending}, 32'd0);
    chk("jal_br_cnt", {16'd0, br_count},        32'd6);
    chk("jal_tk_cnt", {16'd0, br_taken_count},  32'd4);
    idle();

    // JALR links to rd, jumps to rs
    cti(OP_SPECIAL, 5'd0, FN_JALR, 32'h200, 26'd0, 32'h2000, 32'd0);
    id_rd = 5'd5;
    #1;
    chk("jalr_link_we",   {31'd0, link_we}, 32'd1);
    chk("jalr_link_rd",   {27'd0, link_rd}, 32'd5);
    chk("jalr_link_data", link_data,        32'h208);
    tick();
    chk("jalr_pc", pc, 32'h2000);
    idle();

    // Reset while a J redirect is pending
    cti(OP_J, 5'd0, 6'd0, 32'h200, 26'h100, 32'd0, 32'd0);
    if_ready = 1'b0;
    tick();
    chk("j_redir", {31'd0, redirect_pending}, 32'd1);
    reset = 1'b1;
    idle();
    if_ready = 1'b1;
    #1;
    chk("rst2_ifid_we", {31'd0, ifid_write_en}, 32'd0);
    chk("rst2_bubble",  {31'd0, id_bubble},     32'd1);
    tick();
    chk("rst2_pc",     pc,                       32'd0);
    chk("rst2_redir",  {31'd0, redirect_pending}, 32'd0);
    chk("rst2_br_cnt", {16'd0, br_count},        32'd0);
    chk("rst2_tk_cnt", {16'd0, br_taken_count},  32'd0);
    reset = 1'b0;
    tick();
    chk("rst2_no_redir_pc", pc, 32'h4);

    // Saturation of the 2-bit counters over five taken branches
    for (int i = 0; i < 5; i++) begin
      cti(OP_BEQ, 5'd0, 6'd0, 32'h100, 26'h0004, 32'd7, 32'd7);
      tick();
      chk("sat_br_cnt", {30'd0, s_br_count},       (i + 1 > 3) ? 32'd3 : 32'(i + 1));
      chk("sat_tk_cnt", {30'd0, s_br_taken_count}, (i + 1 > 3) ? 32'd3 : 32'(i + 1));
    end
    idle();
    chk("wide_br_cnt", {16'd0, br_count}, 32'd5);
    chk("sat_pc",      s_pc,              32'h114);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_pc_sequencer.md
# branch_pc_sequencer

Owns the fetch PC register of the 5-stage MIPS pipeline and sequences it through branches and jumps resolved in ID. Evaluates the branch condition, computes the target, and stalls the front end while branch operands are not forwarded yet. Holds a resolved redirect until instruction fetch can accept it. Drives IF/ID write-enable, ID/EX bubble insertion, the link-register write, and two saturating branch statistics counters.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- COUNT_WIDTH, 16, width of the statistics counters
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- if_ready  in  1  fetch accepts a new PC this cycle
- id_valid  in  1  ID holds a valid instruction
- id_pc  in  32  PC of the instruction in ID
- id_opcode  in  6  opcode field
- id_rt  in  5  rt field, REGIMM subcode
- id_rd  in  5  rd field, JALR link register
- id_funct  in  6  funct field
- id_imm26  in  26  instr_index; imm16 = id_imm26[15:0]
- rs_value, rt_value  in  32 each  forwarded operands
- operands_ready  in  1  forwarding unit: rs/rt values are current
- pc  out  32  registered fetch PC
- ifid_write_en  out  1  advance IF/ID this cycle
- id_bubble  out  1  replace the ID→EX instruction with a NOP
- link_we  out  1  write link register (one pulse per linking CTI)
- link_rd  out  5  31, or id_rd for JALR
- link_data  out  32  id_pc + 8
- branch_taken  out  1  one-cycle pulse when a taken CTI is dispatched
- redirect_pending  out  1  high in state REDIRECT
- br_count, br_taken_count  out  COUNT_WIDTH each  resolved CTIs / taken CTIs

## Operation
- Supported CTIs:
  - BEQ 000100, BNE 000101, BLEZ 000110, BGTZ 000111.
  - REGIMM 000001 with rt BLTZ 00000, BGEZ 00001, BLTZAL 10000, BGEZAL 10001. BAL is BGEZAL with rs=$0.
  - J 000010, JAL 000011.
  - SPECIAL 000000 with funct JR 001000, JALR 001001.
- Comparisons are signed 32-bit. Anything else is a non-CTI.
- Targets:
  - Branch: id_pc + 4 + (sign-extended imm16 << 2), modulo 2^32.
  - J/JAL: {id_pc+4 [31:28], id_imm26, 2'b00}.
  - JR/JALR: rs_value.
- Not-taken next PC is pc + 4.
- Linking (JAL, JALR, BLTZAL, BGEZAL) writes link_data whether or not the branch is taken. Link write happens only in the dispatch cycle.
- Operand needs: J/JAL need none; every other CTI needs operands_ready.
- Delayed branch: the delay-slot instruction is already being fetched at pc when the CTI sits in ID, and it always executes.
- FSM states:
  - RUN:
    - Non-CTI or no id_valid: if if_ready, pc <= pc+4 and ifid_write_en=1; else hold with id_bubble=1.
    - CTI with operands not ready: go to STALL, hold, id_bubble=1.
    - CTI ready: dispatch (id_bubble=0, link_we if linking, counters update). Then if if_ready, pc <= next_pc and ifid_write_en=1, stay in RUN. Otherwise latch next_pc into target_q and go to REDIRECT.
  - STALL: hold, id_bubble=1, ifid_write_en=0. When operands_ready, behave exactly like a ready CTI in RUN in that same cycle.
  - REDIRECT: the CTI is already dispatched, so id_bubble=1 and link_we=0. When if_ready, pc <= target_q, ifid_write_en=1, go to RUN.
- Counters: increment once per dispatch (br_count always, br_taken_count only if taken). They saturate at all-ones.
- A CTI in a delay slot is resolved normally; the later redirect wins.

## Timing
- Reset: pc=RESET_PC, state RUN, counters 0, target_q 0.
- During a reset cycle: ifid_write_en=0, id_bubble=1, link_we=0, branch_taken=0.
- Reset mid-STALL or mid-REDIRECT drops the pending redirect.
- The redirected PC is visible on pc the cycle after the dispatch edge.
- STALL exit: operands_ready high in cycle N → dispatch in N → pc updated at end of N (if if_ready).
- Combinational outputs depend on the current state and inputs only; no output depends on itself.
- A CTI is dispatched exactly once: no double link write and no double count, even across if_ready low.

## Structure
- Shared package mips_branch_pkg holds:
  - opcode, REGIMM rt and funct constants;
  - the state enum {RUN, STALL, REDIRECT};
  - the link register constant 5'd31.
- Sub-module branch_cond_eval is combinational and sits inside the top.
  - Inputs: opcode/rt/funct/rs_value/rt_value/id_pc/id_imm26.
  - Outputs: is_cti, needs_ops, taken, links, link_is_rd, next_pc.
- The top holds the FSM, pc, target_q and the counters.

## Test plan
- BEQ at id_pc 0x100, rs=rt=5, imm16=0x0004, if_ready=1 → next cycle pc=0x114, branch_taken pulse, br_taken_count=1.
- BLTZ with rs=0xFFFF_FFFF, imm16=0xFFFE → taken; pc=0x100+4-8=0xFC. Also proves the signed compare.
- BGEZAL, operands_ready low 3 cycles:
  - Expect 3 cycles STALL with id_bubble=1 and pc held.
  - Then one link_we with link_rd=31 and link_data=0x108.
- JAL taken with if_ready low 2 cycles:
  - Dispatch once (link_we pulse), then REDIRECT for 2 cycles.
  - pc = target after if_ready rises; br_count=1.
- Reset asserted while in REDIRECT → pc=RESET_PC, state RUN, counters 0, no redirect afterwards.
- COUNT_WIDTH=2, 5 taken branches → both counters stay at 3.
